// File: rtl/var_occ_iter.sv
// Occurrence-range iterator: looks up a variable's {start,end} pair in the
// var_start_end table and streams every index of the inclusive range.
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif

module var_occ_iter #(
    parameter int IDX_BITS = 10
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_valid,
    input  logic [`MAX_VARS_BITS-1:0] req_var,
    output logic                      req_ready,
    output logic                      tbl_read,
    output logic [`MAX_VARS_BITS-1:0] tbl_var,
    input  logic [IDX_BITS-1:0]       tbl_start,
    input  logic [IDX_BITS-1:0]       tbl_end,
    output logic                      idx_valid,
    output logic [IDX_BITS-1:0]       idx,
    output logic                      idx_last,
    input  logic                      idx_ready,
    input  logic                      flush,
    output logic                      done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WALK
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_BITS-1:0] cursor_q, cursor_d;
    logic [IDX_BITS-1:0] end_q, end_d;
    logic                done_q, done_d;

    always_comb begin
        // NOTE: every output and next-state value gets a default first, so no path can infer a latch.
        state_d   = state_q;
        cursor_d  = cursor_q;
        end_d     = end_q;
        done_d    = 1'b0;
        req_ready = 1'b0;
        tbl_read  = 1'b0;
        tbl_var   = req_var;
        idx_valid = 1'b0;
        idx       = cursor_q;
        idx_last  = 1'b0;
        done      = done_q;

        case (state_q)
            ST_IDLE: begin
                req_ready = !flush;
                if (req_valid && !flush) begin
                    tbl_read = 1'b1;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cursor_d = tbl_start;
                end_d    = tbl_end;
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (tbl_start <= tbl_end) begin
                    state_d = ST_WALK;
                end else begin
                    // Empty range finishes right here, without ever presenting an index.
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end
            end
            ST_WALK: begin
                idx_valid = 1'b1;
                idx_last  = (cursor_q == end_q);
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (idx_ready) begin
                    if (idx_last) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cursor_d = cursor_q + IDX_BITS'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are quiet for the whole reset cycle, not only after the edge.
        if (reset) begin
            req_ready = 1'b0;
            tbl_read  = 1'b0;
            idx_valid = 1'b0;
            idx_last  = 1'b0;
            done      = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments only; all decisions live in the always_comb above.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cursor_q <= '0;
            end_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            end_q    <= end_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_var_occ_iter.sv
// Self-checking bench for var_occ_iter: table responder model plus an
// expected-index queue filled per walk and drained on every handshake.
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif

module tb_var_occ_iter;

    localparam int IB = 10;
    localparam int VB = `MAX_VARS_BITS;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid;
    logic [VB-1:0] req_var;
    logic          req_ready;
    logic          tbl_read;
    logic [VB-1:0] tbl_var;
    logic [IB-1:0] tbl_start;
    logic [IB-1:0] tbl_end;
    logic          idx_valid;
    logic [IB-1:0] idx;
    logic          idx_last;
    logic          idx_ready;
    logic          flush;
    logic          done;

    int checks   = 0;
    int failures = 0;

    logic [IB-1:0] tstart [2**VB];
    logic [IB-1:0] tend   [2**VB];

    var_occ_iter #(.IDX_BITS(IB)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_var   (req_var),
        .req_ready (req_ready),
        .tbl_read  (tbl_read),
        .tbl_var   (tbl_var),
        .tbl_start (tbl_start),
        .tbl_end   (tbl_end),
        .idx_valid (idx_valid),
        .idx       (idx),
        .idx_last  (idx_last),
        .idx_ready (idx_ready),
        .flush     (flush),
        .done      (done)
    );

    always #5 clock = ~clock;

    // Table memory with one cycle of read latency.
    always @(posedge clock) begin
        if (tbl_read) begin
            tbl_start <= tstart[tbl_var];
            tbl_end   <= tend[tbl_var];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b1; req_var = VB'(3); idx_ready = 1'b1; flush = 1'b0;
        tbl_start = '0; tbl_end = '0;
        next_cycle();
        @(negedge clock);
        checks++; if (tbl_read !== 1'b0) begin failures++; $display("FAIL reset_tbl_read: got %b want 0", tbl_read); end
        checks++; if (idx_valid !== 1'b0) begin failures++; $display("FAIL reset_idx_valid: got %b want 0", idx_valid); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (idx_last !== 1'b0) begin failures++; $display("FAIL reset_idx_last: got %b want 0", idx_last); end
        next_cycle();
        reset = 1'b0; req_valid = 1'b0; idx_ready = 1'b0;
        @(negedge clock);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL post_reset_req_ready: got %b want 1", req_ready); end
        checks++; if (idx !== IB'(0)) begin failures++; $display("FAIL post_reset_cursor: got %0d want 0", idx); end
        checks++; if (idx_valid !== 1'b0) begin failures++; $display("FAIL post_reset_idx_valid: got %b want 0", idx_valid); end
        next_cycle();
    endtask

    // Full walk: accept, LOAD, WALK with scoreboard; flush_at >= 0 aborts when that idx is shown.
    task automatic do_walk(input logic [VB-1:0] v, input logic [IB-1:0] lo, input logic [IB-1:0] hi,
                           input bit toggle, input int flush_at, input string name);
        logic [IB-1:0] exp_q[$];
        logic [IB-1:0] exp_idx;
        logic [IB-1:0] held;
        bit            prev_stall;
        bit            finished;
        bit            flushed;
        int            c;

        tstart[v] = lo; tend[v] = hi;
        req_valid = 1'b1; req_var = v; idx_ready = 1'b0; flush = 1'b0;
        @(negedge clock);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL %s accept_req_ready: got %b want 1", name, req_ready); end
        checks++; if (tbl_read !== 1'b1) begin failures++; $display("FAIL %s accept_tbl_read: got %b want 1", name, tbl_read); end
        checks++; if (tbl_var !== v) begin failures++; $display("FAIL %s accept_tbl_var: got %0d want %0d", name, tbl_var, v); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL %s accept_done: got %b want 0", name, done); end
        checks++; if (idx_valid !== 1'b0) begin failures++; $display("FAIL %s accept_idx_valid: got %b want 0", name, idx_valid); end
        next_cycle();
        req_valid = 1'b0; req_var = '0;

        @(negedge clock);
        checks++; if (idx_valid !== 1'b0) begin failures++; $display("FAIL %s load_idx_valid: got %b want 0", name, idx_valid); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL %s load_req_ready: got %b want 0", name, req_ready); end
        checks++; if (done !== (lo > hi)) begin failures++; $display("FAIL %s load_done: got %b want %b", name, done, (lo > hi)); end
        next_cycle();
        if (lo > hi) return;

        for (int k = int'(lo); k <= int'(hi); k++) exp_q.push_back(IB'(k));
        prev_stall = 1'b0; finished = 1'b0; flushed = 1'b0; held = '0;
        for (c = 0; c < 64 && !finished; c++) begin
            idx_ready = toggle ? (c % 2 == 0) : 1'b1;
            flush     = (flush_at >= 0) && (exp_q.size() > 0) && (exp_q[0] == IB'(flush_at));
            @(negedge clock);
            checks++; if (idx_valid !== 1'b1) begin failures++; $display("FAIL %s walk_idx_valid: cycle %0d got %b want 1", name, c, idx_valid); end
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL %s walk_done: cycle %0d got %b want 0", name, c, done); end
            checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL %s walk_req_ready: got %b want 0", name, req_ready); end
            if (prev_stall) begin
                checks++; if (idx !== held) begin failures++; $display("FAIL %s hold_idx: got %0d want %0d", name, idx, held); end
            end
            if (flush) begin
                exp_q.delete();
                finished = 1'b1;
                flushed  = 1'b1;
            end else if (idx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL %s extra_idx: got %0d want none", name, idx);
                end else begin
                    exp_idx = exp_q.pop_front();
                    checks++; if (idx !== exp_idx) begin failures++; $display("FAIL %s idx: got %0d want %0d", name, idx, exp_idx); end
                    checks++; if (idx_last !== (exp_idx == hi)) begin failures++; $display("FAIL %s idx_last: at %0d got %b want %b", name, exp_idx, idx_last, (exp_idx == hi)); end
                    if (exp_idx == hi) finished = 1'b1;
                end
            end
            prev_stall = !idx_ready;
            held       = idx;
            next_cycle();
        end
        idx_ready = 1'b0; flush = 1'b0;
        if (!finished) begin
            checks++; failures++;
            $display("FAIL %s timeout: got %0d indices left want 0", name, exp_q.size());
        end
        if (!flushed) begin
            @(negedge clock);
            checks++; if (done !== 1'b1) begin failures++; $display("FAIL %s done_pulse: got %b want 1", name, done); end
            checks++; if (idx_valid !== 1'b0) begin failures++; $display("FAIL %s done_idx_valid: got %b want 0", name, idx_valid); end
            checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL %s done_req_ready: got %b want 1", name, req_ready); end
            next_cycle();
        end
    endtask

    task automatic test_flush_idle();
        flush = 1'b1; req_valid = 1'b1; req_var = VB'(9);
        @(negedge clock);
        checks++; if (tbl_read !== 1'b0) begin failures++; $display("FAIL flush_idle_tbl_read: got %b want 0", tbl_read); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL flush_idle_req_ready: got %b want 0", req_ready); end
        next_cycle();
        flush = 1'b0; req_valid = 1'b0;
        @(negedge clock);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL flush_idle_after_ready: got %b want 1", req_ready); end
        next_cycle();
        @(negedge clock);
        checks++; if (idx_valid !== 1'b0) begin failures++; $display("FAIL flush_idle_no_walk: got %b want 0", idx_valid); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL flush_idle_no_done: got %b want 0", done); end
        next_cycle();
    endtask

    task automatic test_reset_mid_walk();
        tstart[18] = IB'(12); tend[18] = IB'(19);
        req_valid = 1'b1; req_var = VB'(18); idx_ready = 1'b1;
        next_cycle();
        req_valid = 1'b0;
        repeat (4) next_cycle();
        @(negedge clock);
        checks++; if (idx_valid !== 1'b1) begin failures++; $display("FAIL rst_walk_active: got %b want 1", idx_valid); end
        next_cycle();
        reset = 1'b1; req_valid = 1'b1; flush = 1'b1;
        @(negedge clock);
        checks++; if (idx_valid !== 1'b0) begin failures++; $display("FAIL rst_walk_idx_valid: got %b want 0", idx_valid); end
        checks++; if (tbl_read !== 1'b0) begin failures++; $display("FAIL rst_walk_tbl_read: got %b want 0", tbl_read); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_walk_done: got %b want 0", done); end
        next_cycle();
        reset = 1'b0; req_valid = 1'b0; flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++; if (idx_valid !== 1'b0) begin failures++; $display("FAIL rst_after_idx_valid: cycle %0d got %b want 0", i, idx_valid); end
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_after_done: cycle %0d got %b want 0", i, done); end
            checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_after_req_ready: cycle %0d got %b want 1", i, req_ready); end
            checks++; if (idx !== IB'(0)) begin failures++; $display("FAIL rst_after_cursor: cycle %0d got %0d want 0", i, idx); end
            next_cycle();
        end
        idx_ready = 1'b0;
        do_walk(VB'(3), IB'(30), IB'(33), 1'b0, -1, "post_reset_walk");
    endtask

    initial begin
        test_reset();
        do_walk(VB'(18), IB'(12), IB'(19), 1'b0, -1, "basic");
        do_walk(VB'(11), IB'(2), IB'(5), 1'b1, -1, "toggle_ready");
        do_walk(VB'(7), IB'(7), IB'(7), 1'b0, -1, "single");
        do_walk(VB'(4), IB'(5), IB'(2), 1'b0, -1, "empty");
        do_walk(VB'(18), IB'(12), IB'(19), 1'b0, 14, "flush_mid");
        do_walk(VB'(20), IB'(100), IB'(102), 1'b1, -1, "after_flush");
        do_walk(VB'(21), IB'(40), IB'(42), 1'b0, 42, "flush_last");
        do_walk(VB'(5), IB'(1021), IB'(1023), 1'b0, -1, "all_ones_end");
        do_walk(VB'(6), IB'(0), IB'(0), 1'b1, -1, "back_to_back");
        test_flush_idle();
        test_reset_mid_walk();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/var_occ_iter.md
VAR_OCC_ITER -- requirements
Module: var_occ_iter

Interface
REQ-001 SHALL have parameter IDX_BITS, default 10, giving the width of the occurrence-list index held in the var_start_end table.
REQ-002 SHALL use `MAX_VARS_BITS` from sysdefs.svh as the variable-ID width.
REQ-003 SHALL have one clock and synchronous, active-high reset; all state updates on posedge clock.
REQ-004 clock  input  1  system clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 req_valid  input  1  a walk request for req_var is pending.
REQ-007 req_var  input  MAX_VARS_BITS  variable whose occurrence range is walked.
REQ-008 req_ready  output  1  iterator can accept a request.
REQ-009 tbl_read  output  1  read strobe to the var_start_end table.
REQ-010 tbl_var  output  MAX_VARS_BITS  table read address.
REQ-011 tbl_start  input  IDX_BITS  table start index, valid the cycle after tbl_read.
REQ-012 tbl_end  input  IDX_BITS  table end index (inclusive), valid the cycle after tbl_read.
REQ-013 idx_valid  output  1  idx holds a valid occurrence index.
REQ-014 idx  output  IDX_BITS  current occurrence index.
REQ-015 idx_last  output  1  idx is the final index of the range; qualified by idx_valid.
REQ-016 idx_ready  input  1  consumer accepts idx this cycle.
REQ-017 flush  input  1  abort the current walk.
REQ-018 done  output  1  one-cycle pulse when a walk completes normally.

Function
REQ-019 SHALL implement the states IDLE, LOAD and WALK.
REQ-020 IDLE: req_ready=1; on req_valid, tbl_read=1 and tbl_var=req_var in the same cycle (combinational), and the next state is LOAD; otherwise tbl_read=0.
REQ-021 LOAD: capture tbl_start into the cursor and tbl_end into an end register; next state WALK if tbl_start<=tbl_end, otherwise IDLE with done=1 (empty range, no idx_valid).
REQ-022 WALK: idx_valid=1, idx=cursor, idx_last=(cursor==end register).
REQ-023 WALK, idx_valid&idx_ready&!idx_last: cursor increments by 1.
REQ-024 WALK, idx_valid&idx_ready&idx_last: next state IDLE; done=1 on the following cycle (the first IDLE cycle).
REQ-025 WALK, !idx_ready: idx and idx_last hold stable; idx_valid stays 1 (no retraction).
REQ-026 Latency: a request accepted in cycle N SHALL present its first idx_valid in cycle N+2.
REQ-027 Range tbl_start==tbl_end SHALL produce exactly one index, with idx_last=1.
REQ-028 End register = all-ones SHALL terminate on idx_last with no cursor wrap or overrun.
REQ-029 req_ready SHALL be 0 in LOAD and WALK; requests are not queued.
REQ-030 flush in any state SHALL force IDLE next cycle with no done pulse; in the IDLE state flush SHALL suppress tbl_read and request acceptance.
REQ-031 flush together with a final handshake SHALL count as a completed handshake but emit no done.
REQ-032 done SHALL never coincide with idx_valid=1.

Reset
REQ-033 reset SHALL force IDLE, cursor=0, end register=0, idx_valid=0, idx_last=0, done=0 and tbl_read=0; req_ready=1 from the first cycle after reset.
REQ-034 reset asserted mid-WALK SHALL abandon the walk with no further idx_valid and no done.
REQ-035 reset SHALL take priority over flush and all handshakes.

Verification
REQ-036 Reset, then req_valid with req_var=18 and table {12,19}: tbl_read=1 with tbl_var=18 in the accept cycle; idx 12..19 on consecutive cycles with idx_ready=1; idx_last only at 19; done one cycle after 19.
REQ-037 req_var=11, table {2,5}, idx_ready toggled 1,0,1,0...: idx sequence 2,3,4,5 with no skips or duplicates, and idx held while idx_ready=0.
REQ-038 Table {7,7}: a single idx=7 with idx_last=1, then done.
REQ-039 Table {5,2} (empty range): no idx_valid; done pulse in the LOAD cycle; req_ready=1 the next cycle.
REQ-040 flush asserted while idx=14 in a {12,19} walk: IDLE next cycle, no done, and an immediately following request accepted normally.
REQ-041 reset asserted during a WALK, then a new request: all outputs return to reset values, and the new walk starts from its own tbl_start.
